// File: rtl/trace_serializer.sv
// Packs up to three retired instructions per cycle into a FIFO and emits one per cycle on out_*.
// One cycle minimum latency with no bypass; a group that does not fit is dropped whole and counted, and out_* holds while out_ready is low.
module trace_serializer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               trace_rv_i_valid_ip,
  input  logic [95:0]              trace_rv_i_insn_ip,
  input  logic [95:0]              trace_rv_i_address_ip,
  input  logic [2:0]               trace_rv_i_exception_ip,
  input  logic [2:0]               trace_rv_i_interrupt_ip,
  input  logic [4:0]               trace_rv_i_ecause_ip,
  input  logic [31:0]              trace_rv_i_tval_ip,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_insn,
  output logic [31:0]              out_addr,
  output logic                     out_exc,
  output logic                     out_intr,
  output logic [4:0]               out_ecause,
  output logic [31:0]              out_tval,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  entry_t        slot_ent [3];
  entry_t        comp_ent [3];
  logic [1:0]    n_vld;
  logic [1:0]    n_acc;
  logic          deq;
  logic          accept;
  logic          drop;
  logic [AW+1:0] free;
  logic [7:0]    drop_base;
  logic [8:0]    drop_sum;

  // Cause and tval are only meaningful for trapping entries; everything else stores zero.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      slot_ent[s].insn   = trace_rv_i_insn_ip[32*s +: 32];
      slot_ent[s].addr   = trace_rv_i_address_ip[32*s +: 32];
      slot_ent[s].exc    = trace_rv_i_exception_ip[s];
      slot_ent[s].intr   = trace_rv_i_interrupt_ip[s];
      slot_ent[s].ecause = (trace_rv_i_exception_ip[s] | trace_rv_i_interrupt_ip[s]) ?
                           trace_rv_i_ecause_ip : 5'd0;
      slot_ent[s].tval   = (trace_rv_i_exception_ip[s] | trace_rv_i_interrupt_ip[s]) ?
                           trace_rv_i_tval_ip : 32'd0;
    end
  end

  // Squeeze valid slots down to consecutive write lanes, oldest first.
  always_comb begin
    n_vld = 2'd0;
    for (int k = 0; k < 3; k++) comp_ent[k] = '0;
    for (int s = 0; s < 3; s++) begin
      if (trace_rv_i_valid_ip[s]) begin
        comp_ent[n_vld] = slot_ent[s];
        n_vld           = n_vld + 2'd1;
      end
    end
  end

  always_comb begin
    deq       = (occ_q != '0) & out_ready;
    free      = DEPTH_W - {1'b0, occ_q} + {{(AW+1){1'b0}}, deq};
    accept    = ({{AW{1'b0}}, n_vld} <= free);
    drop      = (n_vld != 2'd0) & ~accept;
    n_acc     = accept ? n_vld : 2'd0;
    occ_d     = occ_q + (AW+1)'(n_acc) - (AW+1)'(deq);
    wr_ptr_d  = wr_ptr_q + AW'(n_acc);
    rd_ptr_d  = rd_ptr_q + AW'(deq);
    drop_base = clr_ovf ? 8'd0 : drop_q;
    drop_sum  = {1'b0, drop_base} + {7'd0, n_vld};
    ovf_d     = drop | (ovf_q & ~clr_ovf);
    if (drop) drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    else      drop_d = drop_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: occupancy gates everything visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (accept && (2'(k) < n_vld)) mem_q[wr_ptr_q + AW'(k)] <= comp_ent[k];
    end
  end

  entry_t head;
  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (occ_q != '0);
  assign out_insn   = out_valid ? head.insn   : 32'd0;
  assign out_addr   = out_valid ? head.addr   : 32'd0;
  assign out_exc    = out_valid ? head.exc    : 1'b0;
  assign out_intr   = out_valid ? head.intr   : 1'b0;
  assign out_ecause = out_valid ? head.ecause : 5'd0;
  assign out_tval   = out_valid ? head.tval   : 32'd0;
  assign occupancy  = occ_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;
endmodule

// File: doc/trace_serializer.md
TRACE_SERIALIZER -- requirements
Module: trace_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, minimum 4.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port trace_rv_i_valid_ip, input, 3 bits: per-slot retire valid; slot 0 is oldest.
REQ-005 SHALL have port trace_rv_i_insn_ip, input, 96 bits: slot n instruction in bits [32n+31:32n].
REQ-006 SHALL have port trace_rv_i_address_ip, input, 96 bits: slot n PC in bits [32n+31:32n].
REQ-007 SHALL have port trace_rv_i_exception_ip, input, 3 bits: per-slot exception flag.
REQ-008 SHALL have port trace_rv_i_interrupt_ip, input, 3 bits: per-slot interrupt flag.
REQ-009 SHALL have port trace_rv_i_ecause_ip, input, 5 bits: cause shared by the group.
REQ-010 SHALL have port trace_rv_i_tval_ip, input, 32 bits: tval shared by the group.
REQ-011 SHALL have port out_valid, output, 1 bit: out_* holds a retired instruction.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts when high with out_valid.
REQ-013 SHALL have ports out_insn and out_addr, output, 32 bits each: instruction and PC.
REQ-014 SHALL have ports out_exc and out_intr, output, 1 bit each: exception and interrupt flags.
REQ-015 SHALL have port out_ecause, output, 5 bits: cause, zero when out_exc and out_intr are both 0.
REQ-016 SHALL have port out_tval, output, 32 bits: tval, zero when out_exc and out_intr are both 0.
REQ-017 SHALL have port occupancy, output, clog2(DEPTH)+1 bits: current FIFO entry count.
REQ-018 SHALL have port overflow, output, 1 bit: sticky flag set when a group is dropped.
REQ-019 SHALL have port drop_cnt, output, 8 bits: count of dropped instructions, saturating at 255.
REQ-020 SHALL have port clr_ovf, input, 1 bit: synchronous clear of overflow and drop_cnt.

Function
REQ-021 SHALL convert each cycle's 0-3 valid slots into FIFO entries, written in slot order 0,1,2 and skipping invalid slots.
REQ-022 SHALL compute N = popcount(trace_rv_i_valid_ip) and free = DEPTH - occupancy + deq, where deq = out_valid & out_ready in the same cycle.
REQ-023 SHALL enqueue all N entries when N <= free; otherwise it SHALL enqueue none of them (all-or-nothing), set overflow, and add N to drop_cnt, saturating at 255.
REQ-024 SHALL attach ecause and tval only to entries whose exception or interrupt flag is 1; all other entries SHALL store zero in both fields.
REQ-025 SHALL make an enqueued entry visible on out_* no earlier than the next cycle; there is no input-to-output bypass.
REQ-026 SHALL drive out_valid = (occupancy != 0), with out_* showing the head entry and remaining stable while out_valid=1 and out_ready=0.
REQ-027 SHALL pop the head on out_valid & out_ready, at most one entry per cycle.
REQ-028 SHALL update occupancy by +N(accepted) - deq, with simultaneous enqueue and dequeue allowed.
REQ-029 SHALL wrap read and write pointers modulo DEPTH.
REQ-030 SHALL ignore out_ready while the FIFO is empty, leaving state unchanged.
REQ-031 SHALL, on clr_ovf, zero overflow and drop_cnt next cycle; if a drop occurs in the same cycle, overflow SHALL end at 1 and drop_cnt SHALL end at N.

Reset
REQ-032 SHALL, on rst high, immediately and asynchronously zero pointers, occupancy, out_valid, overflow and drop_cnt.
REQ-033 SHALL drive all out_* data outputs to 0 during reset and while empty.
REQ-034 SHALL discard FIFO contents on reset asserted mid-operation, with no entry emitted after reset release.
REQ-035 SHALL accept inputs starting with the first clock edge after rst deasserts.

Verification
REQ-036 SHALL cover: valid=3'b101, insn slots {A,-,C}, out_ready=1 -> next cycle out_insn=A, following cycle out_insn=C, occupancy sequence 2,1,0.
REQ-037 SHALL cover: DEPTH=8, out_ready=0, four cycles of valid=3'b011 -> occupancy=8, overflow=0; fifth group valid=3'b001 -> dropped, overflow=1, drop_cnt=1, occupancy=8.
REQ-038 SHALL cover: occupancy=7, out_ready=1, valid=3'b011 -> accepted (free=2), occupancy=8 next cycle.
REQ-039 SHALL cover: valid=3'b111, exception=3'b010, ecause=5'd2, tval=0xDEAD -> slot 1 entry carries ecause=2 and tval=0xDEAD, slots 0 and 2 carry 0.
REQ-040 SHALL cover: rst asserted with occupancy=5 -> out_valid=0 and occupancy=0 without a clock edge; no stale entry appears after release.
REQ-041 SHALL cover: drop_cnt=254 and a dropped group of 3 -> drop_cnt=255; clr_ovf -> overflow=0 and drop_cnt=0.
